mem_access_ctrl: RTL

Parametrised successor to memory_control. Decodes LDR/STR opcodes and drives a request/acknowledge RAM port. The port supports variable wait states, so RAM is no longer assumed to answer in one cycle. Adds byte/halfword/word access size, sign extension on loads, alignment faults, a timeout, and a registered write-back to the register file. Sits between the decode/execute stage and the data RAM.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/mem_access_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory access controller: FSM encodings, access
// size codes, opcodes and the address-alignment helper.
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;

  // Address LSBs that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      SZ_BYTE: m = 3'b000;
      SZ_HALF: m = 3'b001;
      SZ_WORD: m = 3'b011;
      SZ_DBL:  m = 3'b111;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store shift, load
// shift/mask/extend and the misalign / illegal-size checks.
module mem_lane_align
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [2:0]          addr_lsb,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   wdata_shift,
  output logic [DATA_W-1:0]   rdata_ext,
  output logic                misalign,
  output logic                size_illegal
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LSB_W = $clog2(BE_W);

  logic [LSB_W-1:0]  lane_s;
  logic [7:0]        base_be_s;
  logic [6:0]        bits_s;
  logic [6:0]        bits_eff_s;
  logic [DATA_W-1:0] mask_s;
  logic [DATA_W-1:0] top_bit_s;
  logic [DATA_W-1:0] rsh_s;
  logic              neg_s;

  assign lane_s = addr_lsb[LSB_W-1:0];

  // Size decode into a base byte mask and the access width in bits.
  always_comb begin
    base_be_s = 8'h01;
    bits_s    = 7'd8;
    case (size)
      SZ_BYTE: begin base_be_s = 8'h01; bits_s = 7'd8;  end
      SZ_HALF: begin base_be_s = 8'h03; bits_s = 7'd16; end
      SZ_WORD: begin base_be_s = 8'h0F; bits_s = 7'd32; end
      SZ_DBL:  begin base_be_s = 8'hFF; bits_s = 7'd64; end
      default: begin base_be_s = 8'h01; bits_s = 7'd8;  end
    endcase
  end

  // A double on a 32-bit path is illegal; clamp so the mask stays well formed.
  assign bits_eff_s   = (bits_s > 7'(DATA_W)) ? 7'(DATA_W) : bits_s;
  assign mask_s       = {DATA_W{1'b1}} >> (7'(DATA_W) - bits_eff_s);
  assign top_bit_s    = mask_s & ~(mask_s >> 1);

  assign be           = base_be_s[BE_W-1:0] << lane_s;
  assign wdata_shift  = wdata << {lane_s, 3'b000};
  assign rsh_s        = rdata >> {lane_s, 3'b000};
  assign neg_s        = sign_ext & (|(rsh_s & top_bit_s));
  assign rdata_ext    = neg_s ? (rsh_s | ~mask_s) : (rsh_s & mask_s);

  assign misalign     = |(addr_lsb & align_mask(size));
  assign size_illegal = (size == SZ_DBL) && (DATA_W != 64);

endmodule

// File: rtl/mem_access_ctrl.sv
// LDR/STR controller driving a req/ack RAM port with variable wait states,
// alignment/size faults, an ack timeout and a registered register write-back.
module mem_access_ctrl #(
  parameter int         DATA_W  = 32,
  parameter int         ADDR_W  = 32,
  parameter logic [3:0] OP_LDR  = mem_ctrl_pkg::OP_LDR,
  parameter logic [3:0] OP_STR  = mem_ctrl_pkg::OP_STR,
  parameter int         TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EN,
  input  logic [3:0]          OpCode,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [ADDR_W-1:0]   src1,
  input  logic [DATA_W-1:0]   src2,
  output logic                ram_req,
  output logic                ram_rw,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic                ram_ack,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                reg_we,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic                busy,
  output logic                done,
  output logic                fault
);

  import mem_ctrl_pkg::*;

  localparam int BE_W  = DATA_W / 8;
  localparam int LSB_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_r;
  logic              is_load_r;
  logic [1:0]        size_r;
  logic              sign_ext_r;
  logic [2:0]        addr_lsb_r;
  logic [CNT_W-1:0]  tmo_cnt_r;

  logic              idle_s;
  logic              accept_s;
  logic [1:0]        al_size_s;
  logic              al_sext_s;
  logic [2:0]        al_lsb_s;
  logic [BE_W-1:0]   be_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rdata_s;
  logic              misalign_s;
  logic              illegal_s;
  logic              tmo_hit_s;

  assign idle_s    = (state_r == ST_IDLE);
  assign accept_s  = idle_s && EN && ((OpCode == OP_LDR) || (OpCode == OP_STR));
  assign tmo_hit_s = (tmo_cnt_r == CNT_W'(TIMEOUT - 1));

  // In IDLE the aligner sees the incoming command, afterwards the latched one.
  always_comb begin
    if (idle_s) begin
      al_size_s = size;
      al_sext_s = sign_ext;
      al_lsb_s  = src1[2:0];
    end else begin
      al_size_s = size_r;
      al_sext_s = sign_ext_r;
      al_lsb_s  = addr_lsb_r;
    end
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size         (al_size_s),
    .sign_ext     (al_sext_s),
    .addr_lsb     (al_lsb_s),
    .wdata        (src2),
    .rdata        (ram_rdata),
    .be           (be_s),
    .wdata_shift  (wdata_s),
    .rdata_ext    (rdata_s),
    .misalign     (misalign_s),
    .size_illegal (illegal_s)
  );

  // Controller FSM; every output is a flop so pulses line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      is_load_r  <= 1'b0;
      size_r     <= 2'b00;
      sign_ext_r <= 1'b0;
      addr_lsb_r <= 3'b000;
      tmo_cnt_r  <= '0;
      ram_req    <= 1'b0;
      ram_rw     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_be     <= '0;
      reg_we     <= 1'b0;
      reg_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      done   <= 1'b0;
      fault  <= 1'b0;
      reg_we <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            is_load_r  <= (OpCode == OP_LDR);
            size_r     <= size;
            sign_ext_r <= sign_ext;
            addr_lsb_r <= src1[2:0];
            tmo_cnt_r  <= '0;
            busy       <= 1'b1;
            if (misalign_s || illegal_s) begin
              state_r <= ST_ERR;
              fault   <= 1'b1;
            end else begin
              state_r   <= ST_REQ;
              ram_req   <= 1'b1;
              ram_rw    <= (OpCode == OP_LDR);
              ram_addr  <= {src1[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
              ram_wdata <= wdata_s;
              ram_be    <= be_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // Ack wins over a timeout landing in the same cycle.
          if (ram_ack) begin
            ram_req   <= 1'b0;
            ram_rw    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_be    <= '0;
            done      <= 1'b1;
            tmo_cnt_r <= '0;
            if (is_load_r) begin
              state_r   <= ST_WB;
              reg_we    <= 1'b1;
              reg_wdata <= rdata_s;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else if (tmo_hit_s) begin
            state_r   <= ST_ERR;
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
            ram_req   <= 1'b0;
            ram_rw    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_be    <= '0;
            fault     <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
          end
        end
        ST_WB: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        ST_ERR: begin
          state_r   <= ST_IDLE;
          busy      <= 1'b0;
          tmo_cnt_r <= '0;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy      <= 1'b0;
          tmo_cnt_r <= '0;
          ram_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
